// File: rtl/demux_stream_ctrl_pkg.sv
// Shared definitions for the demux stream controller: sequencer states,
// channel index type and default sizing.
package demux_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int DEPTH_DEFAULT = 4;

    // Issue sequence for one word: wait for a ready head, let the demux
    // settle, then pulse the strobe.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_e;

    // Destination channel of the 1x4 demux.
    typedef logic [1:0] chan_t;

endpackage

// File: rtl/demux_stream_ctrl_fifo.sv
// Small synchronous FIFO. Pointers wrap naturally because DEPTH is a power
// of two; count carries one extra bit so that full and empty are distinct.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_stream_ctrl.sv
// Upstream sequencer for the 1x4 demux: buffers {dest, data} words and
// issues each one with stable selects, a settle cycle and a strobe pulse.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_valid may be raised independently of in_ready, and in_ready depends
// only on registered state (FIFO not full), never on in_valid.
module demux_stream_ctrl
    import demux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_dest,
    input  logic [3:0]   ch_ready,
    output logic         s0,
    output logic         s1,
    output logic [N-1:0] i0,
    output logic         strobe,
    output logic         busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_STROBE = STROBE;

    logic [1:0]   state;
    logic [N+1:0] head;
    chan_t        head_dest;
    logic [N-1:0] head_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         avail_q;
    logic         pop_go;

    sync_fifo #(
        .WIDTH (N + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid && in_ready),
        .wr_data ({in_dest, in_data}),
        .pop     (pop_go),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_dest = head[N+1:N];
    assign head_data = head[N-1:0];
    assign in_ready  = !fifo_full;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    // A word must sit in the FIFO for one full cycle before IDLE commits to
    // it; this gives the fixed accept-at-E / setup-at-E+2 latency.
    assign pop_go = (state == ST_IDLE) && avail_q && !fifo_empty && ch_ready[head_dest];

    // Registered view of FIFO occupancy used to delay the issue decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q <= 1'b0;
        end else begin
            avail_q <= !fifo_empty;
        end
    end

    // Issue FSM and demux-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            i0     <= '0;
            s0     <= 1'b0;
            s1     <= 1'b0;
            strobe <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    strobe <= 1'b0;
                    if (pop_go) begin
                        i0    <= head_data;
                        s0    <= head_dest[1];
                        s1    <= head_dest[0];
                        state <= ST_SETUP;
                    end else begin
                        // Selects keep their last value so any glitch lands
                        // on the previous channel carrying zero data.
                        i0 <= '0;
                    end
                end
                ST_SETUP: begin
                    strobe <= 1'b1;
                    state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    strobe <= 1'b0;
                    i0     <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    strobe <= 1'b0;
                    i0     <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed bench for demux_stream_ctrl: reset, single issue timing,
// back-to-back fill, head-of-line blocking, pointer wrap with simultaneous
// push/pop, and reset during SETUP.
module tb_demux_stream_ctrl;

    localparam int N = 4;
    localparam int W = N + 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [1:0]   in_dest;
    logic [3:0]   ch_ready;
    logic         s0;
    logic         s1;
    logic [N-1:0] i0;
    logic         strobe;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    int           strobe_cyc[$];

    demux_stream_ctrl #(.N(N), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .ch_ready (ch_ready),
        .s0       (s0),
        .s1       (s1),
        .i0       (i0),
        .strobe   (strobe),
        .busy     (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (strobe) begin
            strobe_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected: got sel=%b%b i0=%h, required no strobe", s0, s1, i0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({s0, s1, i0} !== e) begin
                    failures++;
                    $display("FAIL strobe_word: got %b, required %b", {s0, s1, i0}, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] d, input logic [N-1:0] x, input bit expect_issue);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = x;
        if (expect_issue) exp_q.push_back({d, x});
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (strobe_cyc.size() < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (strobe_cyc.size() !== target) begin
            failures++;
            $display("FAIL %s: got %0d strobes, required %0d", name, strobe_cyc.size(), target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_dest  = 2'd3;
        in_data  = 4'hF;
        ch_ready = 4'hF;
        repeat (3) step();
        checks++;
        if ({in_ready, strobe, s0, s1, i0, busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b stb=%b sel=%b%b i0=%h busy=%b, required 1 0 00 0 0",
                     in_ready, strobe, s0, s1, i0, busy);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (busy !== 1'b0 || strobe_cyc.size() !== 0) begin
            failures++;
            $display("FAIL reset_no_push: got busy=%b strobes=%0d, required 0 0", busy, strobe_cyc.size());
        end
    endtask

    task automatic test_single();
        ch_ready = 4'hF;
        push_word(2'd2, 4'hA, 1'b1);
        step();
        checks++;
        if (i0 !== 4'h0 || strobe !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_e1: got i0=%h stb=%b busy=%b, required 0 0 1", i0, strobe, busy);
        end
        step();
        checks++;
        if ({s0, s1, i0, strobe} !== {1'b1, 1'b0, 4'hA, 1'b0}) begin
            failures++;
            $display("FAIL single_setup: got sel=%b%b i0=%h stb=%b, required 10 a 0", s0, s1, i0, strobe);
        end
        step();
        checks++;
        if ({s0, s1, i0, strobe} !== {1'b1, 1'b0, 4'hA, 1'b1}) begin
            failures++;
            $display("FAIL single_strobe: got sel=%b%b i0=%h stb=%b, required 10 a 1", s0, s1, i0, strobe);
        end
        step();
        checks++;
        if ({s0, s1, i0, strobe, busy} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_after: got sel=%b%b i0=%h stb=%b busy=%b, required 10 0 0 0",
                     s0, s1, i0, strobe, busy);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = strobe_cyc.size();
        ch_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            push_word(2'(k), 4'(k + 1), 1'b1);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full: got in_ready=%b, required 0", in_ready);
        end
        ch_ready = 4'hF;
        wait_strobes(base + 4, 40, "b2b_count");
        for (int k = base + 1; k < strobe_cyc.size(); k++) begin
            checks++;
            if (strobe_cyc[k] - strobe_cyc[k-1] !== 3) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles, required 3", strobe_cyc[k] - strobe_cyc[k-1]);
            end
        end
        wait_idle(20, "b2b_drain");
    endtask

    task automatic test_hol_blocking();
        int base;
        base = strobe_cyc.size();
        ch_ready = 4'b1110;
        push_word(2'd0, 4'h5, 1'b1);
        push_word(2'd1, 4'h6, 1'b1);
        repeat (10) step();
        checks++;
        if (strobe_cyc.size() !== base || busy !== 1'b1) begin
            failures++;
            $display("FAIL hol_blocked: got strobes=%0d busy=%b, required %0d 1", strobe_cyc.size(), busy, base);
        end
        ch_ready = 4'hF;
        wait_strobes(base + 2, 20, "hol_release");
        wait_idle(20, "hol_drain");
    endtask

    task automatic test_wrap();
        int base;
        base = strobe_cyc.size();
        ch_ready = 4'h0;
        push_word(2'd3, 4'h8, 1'b1);
        push_word(2'd2, 4'h9, 1'b1);
        push_word(2'd1, 4'hC, 1'b1);
        step();
        // Push lands on the same edge as the pop of the head.
        ch_ready = 4'hF;
        push_word(2'd0, 4'hD, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pushpop: got in_ready=%b busy=%b, required 1 1", in_ready, busy);
        end
        push_word(2'd3, 4'hE, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL wrap_full: got in_ready=%b, required 0", in_ready);
        end
        wait_strobes(base + 5, 40, "wrap_count");
        wait_idle(20, "wrap_drain");
    endtask

    task automatic test_reset_in_setup();
        int base;
        base = strobe_cyc.size();
        ch_ready = 4'hF;
        push_word(2'd3, 4'h9, 1'b0);
        push_word(2'd1, 4'h7, 1'b0);
        step();
        checks++;
        if ({s0, s1, i0, strobe} !== {1'b1, 1'b1, 4'h9, 1'b0}) begin
            failures++;
            $display("FAIL rst_setup_pre: got sel=%b%b i0=%h stb=%b, required 11 9 0", s0, s1, i0, strobe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, strobe, s0, s1, i0, busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL rst_setup_vals: got rdy=%b stb=%b sel=%b%b i0=%h busy=%b, required 1 0 00 0 0",
                     in_ready, strobe, s0, s1, i0, busy);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        checks++;
        if (strobe_cyc.size() !== base || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_setup_flush: got strobes=%0d busy=%b, required %0d 0", strobe_cyc.size(), busy, base);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dest  = '0;
        ch_ready = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hol_blocking();
        test_wrap();
        test_reset_in_setup();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL leftover_words: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
